// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared state encoding, default widths and watchdog limit for the multiplier arbiter
package arbitro_pkg;
  typedef enum logic [1:0] {IDLE, ARRANQUE, ESPERA} estado_t;
  localparam int DEF_NUM_BITS = 3;
  localparam int DEF_NUM_REQ = 4;
  function automatic int max_ciclos(input int num_bits);
    return 4 * num_bits + 8;
  endfunction
endpackage

// File: rtl/arbitro_rr.sv
// arbitro_rr: combinational round-robin grant searching upward from ptr+1
module arbitro_rr #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] c;
  // scan farthest offset first so the nearest requester after ptr wins
  always_comb begin
    idx = '0;
    c = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[c]) idx = c;
    end
  end
  assign grant = (|req) ? (NUM_REQ'(1) << idx) : '0;
endmodule

// File: rtl/arbitro_multiplicador.sv
// arbitro_multiplicador: round-robin sharing of one sequential multiplier with Fin-edge detection and watchdog
module arbitro_multiplicador
  import arbitro_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_CICLOS = max_ciclos(NUM_BITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*NUM_BITS-1:0] multiplicando_in,
  input  logic [NUM_REQ*NUM_BITS-1:0] multiplicador_in,
  output logic [NUM_REQ-1:0]      ack,
  output logic [NUM_REQ-1:0]      valido,
  output logic                    error,
  output logic [2*NUM_BITS-1:0]   resultado_out,
  output logic                    ocupado,
  output logic [NUM_BITS-1:0]     m_multiplicando,
  output logic [NUM_BITS-1:0]     m_multiplicador,
  output logic                    m_start,
  input  logic [2*NUM_BITS-1:0]   m_resultado,
  input  logic                    m_fin
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_CICLOS + 1);
  estado_t estado;
  logic [IW-1:0] ptr, g_idx;
  logic [NUM_REQ-1:0] g_oh;
  logic fin_prev;
  logic [CW-1:0] cnt;
  logic fin_edge, timeout;
  arbitro_rr #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req(req),
    .ptr(ptr),
    .grant(g_oh),
    .idx(g_idx)
  );
  // edge detection keeps a Fin left high by the previous operation from completing this one
  assign fin_edge = m_fin & ~fin_prev;
  assign timeout = (cnt == CW'(MAX_CICLOS - 1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      fin_prev <= 1'b0;
      cnt <= '0;
      ack <= '0;
      valido <= '0;
      error <= 1'b0;
      resultado_out <= '0;
      ocupado <= 1'b0;
      m_multiplicando <= '0;
      m_multiplicador <= '0;
      m_start <= 1'b0;
    end else begin
      fin_prev <= m_fin;
      ack <= '0;
      valido <= '0;
      error <= 1'b0;
      m_start <= 1'b0;
      case (estado)
        IDLE: if (|req) begin
          ack <= g_oh;
          ptr <= g_idx;
          m_multiplicando <= multiplicando_in[g_idx*NUM_BITS +: NUM_BITS];
          m_multiplicador <= multiplicador_in[g_idx*NUM_BITS +: NUM_BITS];
          m_start <= 1'b1;
          ocupado <= 1'b1;
          estado <= ARRANQUE;
        end
        ARRANQUE: begin
          cnt <= '0;
          estado <= ESPERA;
        end
        ESPERA: begin
          cnt <= cnt + 1'b1;
          if (fin_edge || timeout) begin
            resultado_out <= fin_edge ? m_resultado : '0;
            error <= ~fin_edge;
            valido <= NUM_REQ'(1) << ptr;
            ocupado <= 1'b0;
            estado <= IDLE;
          end
        end
        default: begin
          ocupado <= 1'b0;
          estado <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_multiplicador.sv
// tb_arbitro_multiplicador: directed vectors against a 6-cycle behavioural multiplier model
module tb_arbitro_multiplicador;
  localparam int NB = 3;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*NB-1:0] mcand = '0, mplier = '0;
  logic [NR-1:0] ack, valido;
  logic error, ocupado, m_start, m_fin;
  logic [2*NB-1:0] resultado_out, m_resultado;
  logic [NB-1:0] m_multiplicando, m_multiplicador;
  logic no_fin = 1'b0, hold_fin = 1'b0, busy;
  int mcnt;
  int checks = 0, bad = 0;

  always #5 clk = ~clk;

  arbitro_multiplicador dut (
    .clk(clk), .reset(reset), .req(req),
    .multiplicando_in(mcand), .multiplicador_in(mplier),
    .ack(ack), .valido(valido), .error(error), .resultado_out(resultado_out),
    .ocupado(ocupado), .m_multiplicando(m_multiplicando), .m_multiplicador(m_multiplicador),
    .m_start(m_start), .m_resultado(m_resultado), .m_fin(m_fin)
  );

  // multiplier model: Fin rises 6 edges after start and stays high until the next start
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      mcnt <= 0;
      m_fin <= 1'b0;
      m_resultado <= '0;
    end else if (m_start) begin
      busy <= 1'b1;
      mcnt <= 5;
      if (!hold_fin) m_fin <= 1'b0;
      m_resultado <= {{NB{m_multiplicando[NB-1]}}, m_multiplicando} * {{NB{m_multiplicador[NB-1]}}, m_multiplicador};
    end else if (busy && !no_fin) begin
      if (mcnt == 3) m_fin <= 1'b0;
      if (mcnt == 0) begin
        m_fin <= 1'b1;
        busy <= 1'b0;
      end else mcnt <= mcnt - 1;
    end
  end

  typedef struct {
    int g;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [2*NB-1:0] res;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_ops(input int g, input logic [NB-1:0] a, input logic [NB-1:0] b);
    mcand[g*NB +: NB] = a;
    mplier[g*NB +: NB] = b;
  endtask

  task automatic op(input int g, input logic [NB-1:0] a, input logic [NB-1:0] b,
                    input logic [2*NB-1:0] res, input logic err, input int cyc);
    int n;
    @(negedge clk);
    set_ops(g, a, b);
    req[g] = 1'b1;
    @(posedge clk); #1;
    chk("ack", 32'(ack), 32'(1 << g));
    chk("m_start", 32'(m_start), 32'd1);
    chk("ocupado_busy", 32'(ocupado), 32'd1);
    chk("m_operands", 32'({m_multiplicando, m_multiplicador}), 32'({a, b}));
    req[g] = 1'b0;
    n = 1;
    while (valido == '0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) chk("m_start_pulse", 32'(m_start), 32'd0);
    end
    chk("valido", 32'(valido), 32'(1 << g));
    chk("latency", n, cyc);
    chk("resultado", 32'(resultado_out), 32'(res));
    chk("error", 32'(error), 32'(err));
    chk("ocupado_idle", 32'(ocupado), 32'd0);
  endtask

  task automatic wait_ack(input int g);
    int n = 0;
    while (ack == '0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_rr", 32'(ack), 32'(1 << g));
  endtask

  task automatic wait_val(input int g, input logic [2*NB-1:0] res);
    int n = 0;
    while (valido == '0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valido_rr", 32'(valido), 32'(1 << g));
    chk("resultado_rr", 32'(resultado_out), 32'(res));
    chk("error_rr", 32'(error), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt_v;
    logic [2*NB-1:0] all_res[4];
    tbl[0] = '{1, 3'b100, 3'b100, 6'b010000};
    tbl[1] = '{2, 3'b011, 3'b110, 6'b111010};
    tbl[2] = '{3, 3'b011, 3'b011, 6'b001001};
    tbl[3] = '{0, 3'b111, 3'b100, 6'b000100};
    tbl[4] = '{2, 3'b100, 3'b011, 6'b110100};
    tbl[5] = '{1, 3'b101, 3'b010, 6'b111010};
    tbl[6] = '{3, 3'b100, 3'b111, 6'b000100};
    #1;
    chk("reset_outputs", 32'({ack, valido, error, resultado_out, ocupado, m_multiplicando, m_multiplicador, m_start}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // all four requesters held from reset: grants rotate 0,1,2,3,0
    set_ops(0, 3'b001, 3'b010);
    set_ops(1, 3'b100, 3'b100);
    set_ops(2, 3'b011, 3'b110);
    set_ops(3, 3'b111, 3'b011);
    all_res = '{6'b000010, 6'b010000, 6'b111010, 6'b111101};
    @(negedge clk);
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_ack(i % 4);
      wait_val(i % 4, all_res[i % 4]);
    end
    @(negedge clk);
    req = '0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 7; i++) op(tbl[i].g, tbl[i].a, tbl[i].b, tbl[i].res, 1'b0, 9);

    for (int ia = -4; ia < 4; ia++)
      for (int ib = -4; ib < 4; ib++)
        op(0, 3'(ia), 3'(ib), 6'(ia * ib), 1'b0, 9);

    no_fin = 1'b1;
    op(1, 3'b010, 3'b011, 6'b000000, 1'b1, 22);
    no_fin = 1'b0;
    op(2, 3'b011, 3'b110, 6'b111010, 1'b0, 9);

    // Fin still high from the previous operation across the new start
    hold_fin = 1'b1;
    op(3, 3'b100, 3'b100, 6'b010000, 1'b0, 9);
    hold_fin = 1'b0;

    // reset in the middle of ESPERA, then requesters 0 and 3 compete
    @(negedge clk);
    set_ops(2, 3'b011, 3'b011);
    req[2] = 1'b1;
    @(posedge clk); #1;
    chk("ack_pre_reset", 32'(ack), 32'd4);
    req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_mid_op", 32'({ack, valido, error, resultado_out, ocupado, m_multiplicando, m_multiplicador, m_start}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt_v = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (valido != '0 || error || m_start) cnt_v++;
    end
    chk("no_valido_after_reset", cnt_v, 0);
    @(negedge clk);
    set_ops(0, 3'b010, 3'b101);
    set_ops(3, 3'b011, 3'b011);
    req = 4'b1001;
    wait_ack(0);
    req[0] = 1'b0;
    wait_val(0, 6'b111010);
    wait_ack(3);
    req[3] = 1'b0;
    wait_val(3, 6'b001001);

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule
